// File: rtl/vx_gpu_pkg.sv
// Shared GPU-side types for the global barrier path. The request/response
// structs are also used by the core-side scheduler, so their field widths
// follow the package-level barrier configuration below.
package vx_gpu_pkg;

    // Minimum-one-bit log2, used for index and count widths.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GBAR_NUM_CORES    = 4;
    localparam int GBAR_NUM_BARRIERS = 4;
    localparam int GBAR_CW           = clog2_min1(GBAR_NUM_CORES);
    localparam int GBAR_BW           = clog2_min1(GBAR_NUM_BARRIERS);

    // One barrier arrival as seen by the barrier unit.
    typedef struct packed {
        logic [GBAR_BW-1:0] id;
        logic [GBAR_CW-1:0] size_m1;
        logic [GBAR_CW-1:0] core_id;
    } gbar_req_t;

    // Broadcast release of one barrier.
    typedef struct packed {
        logic [GBAR_BW-1:0] id;
    } gbar_rsp_t;

endpackage

// File: rtl/vx_generic_arbiter.sv
// Generic request arbiter. TYPE "R" rotates priority past each granted index
// on a handshake; any other TYPE keeps fixed priority starting at index 0.
// LOCK_ENABLE holds a grant that has not been accepted yet.
//
// Handshake: a grant completes on the cycle where grant_valid && grant_ready
// are both high; only then does the priority pointer move.
module vx_generic_arbiter #(
    parameter int    NUM_REQS     = 4,
    parameter string TYPE         = "R",
    parameter bit    LOCK_ENABLE  = 1'b0,
    parameter int    LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQS-1:0]     requests,
    output logic [LOG_NUM_REQS-1:0] grant_index,
    output logic [NUM_REQS-1:0]     grant_onehot,
    output logic                    grant_valid,
    input  logic                    grant_ready
);

    localparam int LW     = LOG_NUM_REQS;
    localparam bit ROTATE = (TYPE == "R");

    logic [LW-1:0] ptr_q, ptr_d;
    logic          locked_q, locked_d;
    logic [LW-1:0] lock_idx_q, lock_idx_d;
    logic [LW-1:0] pick_idx;
    logic          pick_valid;

    // Find the first asserted request at or after the priority pointer.
    always_comb begin : search
        int idx;
        pick_idx   = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQS;
            if (!pick_valid && requests[LW'(idx)]) begin
                pick_valid = 1'b1;
                pick_idx   = LW'(idx);
            end
        end
    end

    // Select between a held (locked) grant and the fresh search result.
    always_comb begin : grant_sel
        grant_index = pick_idx;
        grant_valid = pick_valid;
        if (locked_q && requests[lock_idx_q]) begin
            grant_index = lock_idx_q;
            grant_valid = 1'b1;
        end
        grant_onehot = grant_valid ? (NUM_REQS'(1) << grant_index) : '0;
    end

    // Advance the pointer on handshake; optionally hold an unaccepted grant.
    always_comb begin : next_state
        ptr_d      = ptr_q;
        locked_d   = 1'b0;
        lock_idx_d = lock_idx_q;
        if (grant_valid && grant_ready) begin
            if (ROTATE) begin
                ptr_d = (grant_index == LW'(NUM_REQS - 1)) ? '0 : grant_index + LW'(1);
            end
        end else if (LOCK_ENABLE && grant_valid) begin
            locked_d   = 1'b1;
            lock_idx_d = grant_index;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/vx_gbar_unit.sv
// Global barrier unit. Cores announce arrival at a barrier id; once the
// required number of distinct cores has arrived, a single release pulse is
// broadcast one cycle later and the barrier starts a fresh epoch.
//
// Optional feature: define GBAR_PERF_EN to add perf_releases / perf_stalls.
//
// Handshake: a request fires when req_valid[i] && req_ready[i]. req_ready is
// one-hot (or zero) and depends only on round-robin arbitration, never on
// barrier state; it is forced low while reset is high.
module vx_gbar_unit
    import vx_gpu_pkg::*;
#(
    parameter string INSTANCE_ID   = "",
    parameter int    NUM_CORES     = GBAR_NUM_CORES,
    parameter int    NUM_BARRIERS  = GBAR_NUM_BARRIERS,
`ifdef GBAR_PERF_EN
    parameter int    PERF_CTR_BITS = 32,
`endif
    localparam int   CW            = clog2_min1(NUM_CORES),
    localparam int   BW            = clog2_min1(NUM_BARRIERS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CORES-1:0]           req_valid,
    input  logic [NUM_CORES-1:0][BW-1:0]   req_id,
    input  logic [NUM_CORES-1:0][CW-1:0]   req_size_m1,
    input  logic [NUM_CORES-1:0][CW-1:0]   req_core_id,
    output logic [NUM_CORES-1:0]           req_ready,
    output logic                           rsp_valid,
    output logic [BW-1:0]                  rsp_id
`ifdef GBAR_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]       perf_releases,
    output logic [PERF_CTR_BITS-1:0]       perf_stalls
`endif
);

    logic [CW-1:0]        grant_idx;
    logic [NUM_CORES-1:0] grant_onehot;
    logic                 grant_valid;
    logic                 fire;

    gbar_req_t            sel_req;
    logic [BW-1:0]        sel_id;
    logic [CW-1:0]        sel_size;
    logic [CW-1:0]        sel_core;
    logic [NUM_CORES-1:0] sel_mask;
    logic                 dup_fire;

    logic [CW-1:0]        ctr_q  [NUM_BARRIERS];
    logic [CW-1:0]        ctr_d  [NUM_BARRIERS];
    logic [NUM_CORES-1:0] mask_q [NUM_BARRIERS];
    logic [NUM_CORES-1:0] mask_d [NUM_BARRIERS];
    gbar_rsp_t            rsp_q, rsp_d;
    logic                 rsp_valid_q, rsp_valid_d;

    vx_generic_arbiter #(
        .NUM_REQS     (NUM_CORES),
        .TYPE         ("R"),
        .LOCK_ENABLE  (1'b0),
        .LOG_NUM_REQS (CW)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .requests     (req_valid),
        .grant_index  (grant_idx),
        .grant_onehot (grant_onehot),
        .grant_valid  (grant_valid),
        .grant_ready  (fire)
    );

    // Accept only the granted core; nothing is accepted during reset.
    always_comb begin : accept
        req_ready = reset ? '0 : grant_onehot;
        fire      = grant_valid && !reset;
    end

    // Gather the granted core's request into the shared request struct.
    always_comb begin : select
        sel_req.id      = GBAR_BW'(req_id[grant_idx]);
        sel_req.size_m1 = GBAR_CW'(req_size_m1[grant_idx]);
        sel_req.core_id = GBAR_CW'(req_core_id[grant_idx]);
        sel_id          = BW'(sel_req.id);
        sel_size        = CW'(sel_req.size_m1);
        sel_core        = CW'(sel_req.core_id);
        sel_mask        = mask_q[sel_id];
        dup_fire        = fire && sel_mask[sel_core];
    end

    // Count arrivals per barrier; the arrival that matches size_m1 releases.
    always_comb begin : barrier_update
        ctr_d       = ctr_q;
        mask_d      = mask_q;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;
        if (fire && !dup_fire) begin
            if (ctr_q[sel_id] == sel_size) begin
                ctr_d[sel_id]  = '0;
                mask_d[sel_id] = '0;
                rsp_valid_d    = 1'b1;
                rsp_d.id       = GBAR_BW'(sel_id);
            end else begin
                ctr_d[sel_id]            = ctr_q[sel_id] + CW'(1);
                mask_d[sel_id][sel_core] = 1'b1;
            end
        end
    end

    // Barrier state and release register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                ctr_q[b]  <= '0;
                mask_q[b] <= '0;
            end
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            ctr_q       <= ctr_d;
            mask_q      <= mask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = BW'(rsp_q.id);

    // Report a core arriving twice at the same barrier epoch (ignored).
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!dup_fire)
            else $warning("%s: duplicate barrier arrival core=%0d id=%0d",
                          INSTANCE_ID, sel_core, sel_id);
        end
    end

`ifdef GBAR_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_rel_q, perf_rel_d;
    logic [PERF_CTR_BITS-1:0] perf_stall_q, perf_stall_d;

    // Count release pulses and cycles where some valid request waits.
    always_comb begin : perf_next
        perf_rel_d   = perf_rel_q + PERF_CTR_BITS'(rsp_valid_q);
        perf_stall_d = perf_stall_q + PERF_CTR_BITS'(|(req_valid & ~req_ready));
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_rel_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_rel_q   <= perf_rel_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_releases = perf_rel_q;
    assign perf_stalls   = perf_stall_q;
`endif

endmodule

// File: tb/tb_vx_gbar_unit.sv
// Directed testbench for vx_gbar_unit (4 cores, 4 barriers).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_vx_gbar_unit;

    localparam int NC = 4;
    localparam int CW = 2;
    localparam int BW = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NC-1:0]         req_valid;
    logic [NC-1:0][BW-1:0] req_id;
    logic [NC-1:0][CW-1:0] req_size_m1;
    logic [NC-1:0][CW-1:0] req_core_id;
    logic [NC-1:0]         req_ready;
    logic                  rsp_valid;
    logic [BW-1:0]         rsp_id;
`ifdef GBAR_PERF_EN
    logic [31:0]           perf_releases;
    logic [31:0]           perf_stalls;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Clock.
    always #5 clk = ~clk;

    vx_gbar_unit #(
        .INSTANCE_ID  ("gbar0"),
        .NUM_CORES    (NC),
        .NUM_BARRIERS (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_size_m1 (req_size_m1),
        .req_core_id (req_core_id),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id)
`ifdef GBAR_PERF_EN
        ,
        .perf_releases (perf_releases),
        .perf_stalls   (perf_stalls)
`endif
    );

    // Driver: hold reset for two cycles, ending on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Driver: one request from a single core; checks it is granted and
    // returns on the falling edge after the handshake.
    task automatic issue(input int core, input logic [1:0] id,
                         input logic [1:0] sm1, input logic [1:0] cid);
        logic [3:0] exp_rdy;
        exp_rdy               = 4'b0001 << core;
        req_valid             = exp_rdy;
        req_id[core[1:0]]      = id;
        req_size_m1[core[1:0]] = sm1;
        req_core_id[core[1:0]] = cid;
        #1;
        n_cmp++;
        if (req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL issue_ready core%0d: got %b want %b", core, req_ready, exp_rdy);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        req_valid   = 4'hF;
        req_id      = '0;
        req_size_m1 = '0;
        req_core_id = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (req_ready !== 4'h0) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        end
        n_cmp++;
        if (rsp_id !== 2'd0) begin
            n_err++;
            $display("FAIL reset_rsp_id: got %0d want 0", rsp_id);
        end
        req_valid = '0;
        reset     = 1'b0;
        @(negedge clk);
    endtask

    // Cores 0..3 arrive one per cycle at id 1, then a size-one reuse of id 1.
    task automatic test_sequential();
        logic [3:0] exp_v;
        exp_v = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            issue(c, 2'd1, 2'd3, 2'(c));
            n_cmp++;
            if (rsp_valid !== exp_v[c]) begin
                n_err++;
                $display("FAIL seq_rsp_valid step%0d: got %b want %b", c, rsp_valid, exp_v[c]);
            end
        end
        n_cmp++;
        if (rsp_id !== 2'd1) begin
            n_err++;
            $display("FAIL seq_rsp_id: got %0d want 1", rsp_id);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL seq_single_pulse: got %b want 0", rsp_valid);
        end
        issue(0, 2'd1, 2'd0, 2'd0);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
            n_err++;
            $display("FAIL seq_ctr_cleared: got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id);
        end
    endtask

    // All cores request id 2 together; expect grants 0,1,2,3 then one release.
    task automatic test_all_at_once();
        logic [3:0] exp_rdy;
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_id[i]      = 2'd2;
            req_size_m1[i] = 2'd3;
            req_core_id[i] = 2'(i);
        end
        for (int g = 0; g < 4; g++) begin
            #1;
            exp_rdy = 4'b0001 << g;
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL all_grant%0d: got %b want %b", g, req_ready, exp_rdy);
            end
            @(negedge clk);
            req_valid[g] = 1'b0;
            n_cmp++;
            if (rsp_valid !== (g == 3)) begin
                n_err++;
                $display("FAIL all_rsp_valid%0d: got %b want %b", g, rsp_valid, (g == 3));
            end
        end
        n_cmp++;
        if (rsp_id !== 2'd2) begin
            n_err++;
            $display("FAIL all_rsp_id: got %0d want 2", rsp_id);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL all_single_pulse: got %b want 0", rsp_valid);
        end
`ifdef GBAR_PERF_EN
        n_cmp++;
        if (perf_releases !== 32'd1) begin
            n_err++;
            $display("FAIL perf_releases: got %0d want 1", perf_releases);
        end
        n_cmp++;
        if (perf_stalls !== 32'd3) begin
            n_err++;
            $display("FAIL perf_stalls: got %0d want 3", perf_stalls);
        end
`endif
    endtask

    // size_m1=0 from core 2 every cycle gives a release every cycle.
    task automatic test_size_one();
        req_valid      = 4'b0100;
        req_id[2]      = 2'd0;
        req_size_m1[2] = 2'd0;
        req_core_id[2] = 2'd2;
        for (int n = 0; n < 4; n++) begin
            #1;
            n_cmp++;
            if (req_ready !== 4'b0100) begin
                n_err++;
                $display("FAIL one_ready%0d: got %b want 0100", n, req_ready);
            end
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
                n_err++;
                $display("FAIL one_rsp%0d: got v=%b id=%0d want v=1 id=0", n, rsp_valid, rsp_id);
            end
        end
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL one_idle: got %b want 0", rsp_valid);
        end
    endtask

    // Run a table of single requests, checking the response after each.
    task automatic run_table(input string name, input int cores[5],
                             input logic [1:0] ids[5], input logic [1:0] sm1[5],
                             input logic [4:0] exp_v, input logic [1:0] exp_id[5]);
        for (int i = 0; i < 5; i++) begin
            if (cores[i] < 0) begin
                @(negedge clk);
            end else begin
                issue(cores[i], ids[i], sm1[i], 2'(cores[i]));
            end
            n_cmp++;
            if (rsp_valid !== exp_v[i] || (exp_v[i] && rsp_id !== exp_id[i])) begin
                n_err++;
                $display("FAIL %s step%0d: got v=%b id=%0d want v=%b id=%0d",
                         name, i, rsp_valid, rsp_id, exp_v[i], exp_id[i]);
            end
        end
    endtask

    // Ids 0 and 3 interleaved, completing in consecutive cycles.
    task automatic test_back_to_back();
        run_table("b2b", '{0, 1, 1, 0, -1}, '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0},
                  '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0}, 5'b01100,
                  '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0});
    endtask

    // A request in the cycle the release is driven starts a new epoch.
    task automatic test_new_epoch();
        run_table("epoch", '{0, 1, 2, 3, -1}, '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0},
                  '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0}, 5'b01010,
                  '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0});
    endtask

    // Core 1 arrives twice: the repeat must not count toward the release.
    task automatic test_duplicate();
        run_table("dup", '{1, 1, 0, 2, -1}, '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0},
                  '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0}, 5'b01000,
                  '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0});
    endtask

    // Reset with a partial barrier pending: no release, state starts clean.
    task automatic test_reset_mid();
        issue(1, 2'd1, 2'd3, 2'd1);
        issue(2, 2'd1, 2'd3, 2'd2);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_during: got %b want 0", rsp_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_after: got %b want 0", rsp_valid);
        end
        run_table("rmid", '{1, 2, -1, -1, -1}, '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0},
                  '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0}, 5'b00010,
                  '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0});
    endtask

    initial begin
        req_valid   = '0;
        req_id      = '0;
        req_size_m1 = '0;
        req_core_id = '0;
        reset       = 1'b1;
        test_reset();
        test_sequential();
        test_all_at_once();
        test_size_one();
        test_back_to_back();
        test_new_epoch();
        test_duplicate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vx_gbar_unit.md
VX_GBAR_UNIT -- requirements
Module: VX_gbar_unit

Interface
REQ-001 SHALL have parameter: INSTANCE_ID, "", instance name used in assertion messages.
REQ-002 SHALL have parameter: NUM_CORES, 4, number of requesting cores (>=1); CW = max(1, clog2(NUM_CORES)).
REQ-003 SHALL have parameter: NUM_BARRIERS, 4, barrier ids (>=1); BW = max(1, clog2(NUM_BARRIERS)).
REQ-004 SHALL have port: clk  in  1  sole clock; all logic on posedge clk.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: req_valid  in  NUM_CORES  per-core barrier-arrival request.
REQ-007 SHALL have port: req_id  in  NUM_CORES x BW  per-core barrier id.
REQ-008 SHALL have port: req_size_m1  in  NUM_CORES x CW  per-core participating core count minus one.
REQ-009 SHALL have port: req_core_id  in  NUM_CORES x CW  per-core sender core id.
REQ-010 SHALL have port: req_ready  out  NUM_CORES  per-core accept; one-hot or zero.
REQ-011 SHALL have port: rsp_valid  out  1  broadcast release pulse to all cores.
REQ-012 SHALL have port: rsp_id  out  BW  id of released barrier.

Function
REQ-013 SHALL accept at most one request per cycle, granted round-robin among asserted req_valid; priority pointer advances past the granted index after each handshake.
REQ-014 SHALL assert req_ready[i] combinationally only for the granted index; request fires when req_valid[i] && req_ready[i].
REQ-015 SHALL keep per barrier: arrival counter ctr[id] (CW bits) and arrival mask mask[id] (NUM_CORES bits).
REQ-016 On fire with ctr[id] != size_m1: ctr[id] += 1, set mask[id][core_id]; no response.
REQ-017 On fire with ctr[id] == size_m1 (release): clear ctr[id] and mask[id]; next cycle rsp_valid=1, rsp_id=id, for exactly one cycle.
REQ-018 Release latency SHALL be exactly 1 cycle from the completing handshake; size_m1=0 releases on first arrival.
REQ-019 size_m1 of the completing request SHALL be used; counter compare is CW-bit exact, no wrap beyond size_m1.
REQ-020 A fire whose core_id bit is already set in mask[id] SHALL be a duplicate: state unchanged, runtime assertion fires with INSTANCE_ID, core and id.
REQ-021 Releases of distinct ids in consecutive cycles SHALL produce back-to-back rsp pulses; no response is ever dropped or merged.
REQ-022 A request to an id in the same cycle its release response is driven SHALL count toward a new epoch (ctr already zero).
REQ-023 No request SHALL be stalled by barrier state; req_ready depends only on arbitration.

Reset
REQ-024 On reset: ctr, mask all zero; rsp_valid=0; rsp_id=0; arbiter pointer at index 0; req_ready=0 during reset.
REQ-025 Reset mid-operation SHALL discard all partial arrivals without issuing responses.

Configuration
REQ-026 Macro GBAR_PERF_EN: when defined, add outputs perf_releases (PERF_CTR_BITS, count of rsp pulses) and perf_stalls (PERF_CTR_BITS, cycles with some req_valid[i] && !req_ready[i]), both zeroed on reset; when undefined, ports and counters absent, behaviour otherwise identical.

Structure
REQ-027 gbar_req_t {id, size_m1, core_id} and gbar_rsp_t {id} SHALL live in VX_gpu_pkg, shared with the core-side scheduler.
REQ-028 Round-robin grant SHALL use sub-module VX_generic_arbiter (TYPE "R", LOCK_ENABLE 0); counters/masks and response register are local.

Verification
REQ-029 NUM_CORES=4: cores 0..3 request id=1, size_m1=3 in cycles 0..3 -> rsp_valid=1, rsp_id=1 in cycle 4 only; ctr[1]=0 afterward.
REQ-030 All 4 cores assert req_valid same cycle, id=2, size_m1=3 -> grants 0,1,2,3 over 4 cycles, one each; single rsp id=2 one cycle after last grant.
REQ-031 size_m1=0 from core 2, id=0 -> rsp id=0 next cycle; repeated every cycle -> continuous pulses.
REQ-032 Interleaved ids 0 and 3 (size_m1=1) completing in consecutive cycles -> rsp ids 0 then 3 back-to-back.
REQ-033 Core 1 sends id=1 twice before release -> assertion fires, ctr[1] stays 1; reset asserted mid-barrier -> no rsp, state zero.
REQ-034 With GBAR_PERF_EN, scenario REQ-030 -> perf_releases=1, perf_stalls=3.
